tx_buffer: RTL

- Transmit-direction counterpart of the SPI receive buffer. The host acts as SPI master and writes 32-bit sample words MSB-first on MOSI.
- The block assembles these words, queues them in an internal FIFO and releases one I/Q pair per txstrobe to the TX datapath.
- The whole block runs on tx_clk. SPI pins are oversampled, and a status word is returned on MISO during each transfer.

---
 rtl/tx_buffer_if.sv | 37 +++
 rtl/tx_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tx_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_buffer_if
// Purpose  : SPI pins, TX strobe/sample path and status flags of tx_buffer.
// Revision : 1.0  initial release
// ============================================================================
interface tx_buffer_if #(
    parameter int FIFO_AW = 10
);
    logic               spi_clk;
    logic               spi_cs_n;
    logic               spi_input;
    logic               spi_output;
    logic               txstrobe;
    logic               clear_status;
    logic [15:0]        tx_i;
    logic [15:0]        tx_q;
    logic               tx_valid;
    logic               have_space;
    logic               tx_overrun;
    logic               tx_underrun;
    logic [FIFO_AW:0]   fifo_level;

    modport master (
        output spi_clk, spi_cs_n, spi_input, txstrobe, clear_status,
        input  spi_output, tx_i, tx_q, tx_valid, have_space,
               tx_overrun, tx_underrun, fifo_level
    );

    modport slave (
        input  spi_clk, spi_cs_n, spi_input, txstrobe, clear_status,
        output spi_output, tx_i, tx_q, tx_valid, have_space,
               tx_overrun, tx_underrun, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/tx_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_buffer
// Purpose  : SPI-slave word assembler feeding a FIFO that releases I/Q pairs
//            per txstrobe; returns a status word on MISO.
// Revision : 1.0  initial release
// ============================================================================
module tx_buffer #(
    parameter int FIFO_AW      = 10,
    parameter int SPACE_THRESH = 512,
    parameter int SYNC_STAGES  = 2
) (
    input  wire        tx_clk,
    input  wire        reset,
    tx_buffer_if.slave bus
);
    localparam int c_DEPTH = 2 ** FIFO_AW;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   armed_q,     armed_d;
    logic [4:0]             bit_cnt_q,   bit_cnt_d;
    logic [30:0]            shift_q,     shift_d;
    logic                   wr_req_q,    wr_req_d;
    logic [31:0]            wr_word_q,   wr_word_d;
    logic [FIFO_AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [FIFO_AW-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [FIFO_AW:0]       level_q,     level_d;
    logic [15:0]            tx_i_q,      tx_i_d;
    logic [15:0]            tx_q_q,      tx_q_d;
    logic                   tx_valid_q,  tx_valid_d;
    logic                   have_space_q, have_space_d;
    logic                   overrun_q,   overrun_d;
    logic                   underrun_q,  underrun_d;
    logic [31:0]            status_q,    status_d;
    logic [31:0]            mem [c_DEPTH];

    logic        w_sclk, w_cs_n, w_mosi;
    logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_active;
    logic        w_empty, w_full, w_pop, w_push, w_underrun, w_overrun;
    logic [31:0] w_rx_word, w_rd_word, w_status;

    assign sclk_sync_d[0] = bus.spi_clk;
    assign cs_sync_d[0]   = bus.spi_cs_n;
    assign mosi_sync_d[0] = bus.spi_input;
    for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
        assign sclk_sync_d[i] = sclk_sync_q[i-1];
        assign cs_sync_d[i]   = cs_sync_q[i-1];
        assign mosi_sync_d[i] = mosi_sync_q[i-1];
    end

    assign w_sclk      = sclk_sync_q[SYNC_STAGES-1];
    assign w_cs_n      = cs_sync_q[SYNC_STAGES-1];
    assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk & sclk_prev_q;
    // armed_q blocks a transfer already in flight when reset released
    assign w_cs_active = armed_q & ~w_cs_n;
    assign w_cs_fall   = w_cs_active & cs_prev_q;
    assign w_rx_word   = {shift_q, w_mosi};

    assign w_empty    = (level_q == '0);
    assign w_full     = level_q[FIFO_AW];
    assign w_pop      = bus.txstrobe & ~w_empty;
    assign w_underrun = bus.txstrobe & w_empty;
    assign w_push     = wr_req_q & (~w_full | w_pop);
    assign w_overrun  = wr_req_q & ~w_push;
    assign w_rd_word  = mem[rd_ptr_q];
    assign w_status   = {overrun_q, underrun_q, have_space_q, 13'b0, 16'(level_q)};

    always_comb begin
        sclk_prev_d = w_sclk;
        cs_prev_d   = w_cs_n;
        armed_d     = armed_q | w_cs_n;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_req_d    = 1'b0;
        wr_word_d   = wr_word_q;
        status_d    = status_q;

        if (!w_cs_active || w_cs_fall) begin
            bit_cnt_d = 5'd0;
        end else if (w_sclk_rise) begin
            shift_d   = w_rx_word[30:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
                wr_req_d  = 1'b1;
                wr_word_d = w_rx_word;
            end
        end

        // The falling edge that closes a word reloads rather than shifts,
        // so the next word's first rising edge sees a fresh MSB.
        if (w_cs_fall) begin
            status_d = w_status;
        end else if (w_cs_active && w_sclk_fall) begin
            status_d = (bit_cnt_q == 5'd0) ? w_status : {status_q[30:0], 1'b0};
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        tx_i_d       = tx_i_q;
        tx_q_d       = tx_q_q;
        tx_valid_d   = w_pop;
        have_space_d = (c_DEPTH - int'(level_q)) >= SPACE_THRESH;
        overrun_d    = (overrun_q  & ~bus.clear_status) | w_overrun;
        underrun_d   = (underrun_q & ~bus.clear_status) | w_underrun;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            tx_i_d   = w_rd_word[15:0];
            tx_q_d   = w_rd_word[31:16];
        end else if (w_underrun) begin
            tx_i_d = 16'd0;
            tx_q_d = 16'd0;
        end

        if (w_push && !w_pop) begin
            level_d = level_q + 1'b1;
        end else if (!w_push && w_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b0;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 5'd0;
            shift_q      <= '0;
            wr_req_q     <= 1'b0;
            wr_word_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            tx_i_q       <= '0;
            tx_q_q       <= '0;
            tx_valid_q   <= 1'b0;
            have_space_q <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            status_q     <= '0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            wr_req_q     <= wr_req_d;
            wr_word_q    <= wr_word_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            tx_i_q       <= tx_i_d;
            tx_q_q       <= tx_q_d;
            tx_valid_q   <= tx_valid_d;
            have_space_q <= have_space_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
            status_q     <= status_d;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (w_push) begin
            mem[wr_ptr_q] <= wr_word_q;
        end
    end

    assign bus.spi_output  = w_cs_active & status_q[31];
    assign bus.tx_i        = tx_i_q;
    assign bus.tx_q        = tx_q_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.have_space  = have_space_q;
    assign bus.tx_overrun  = overrun_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.fifo_level  = level_q;
endmodule
`default_nettype wire
